load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - 32-bit load/store unit bridging core requests to a gnt/rvalid memory port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses complete with misaligned=1 and no memory request.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic        load_req,
  input  logic        store_req,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q;
  logic        is_load_q;
  logic [1:0]  lane_q;
  logic [2:0]  size_q;
  logic        mem_req_q, mem_we_q, done_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;

  logic [31:0] eff_addr;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;

  // Without the trap, offending low address bits are dropped so the access stays aligned.
  always_comb begin
    eff_addr = addr;
    case (funct3[1:0])
      2'b00:   eff_addr = addr;
      2'b01:   eff_addr[0] = 1'b0;
      default: eff_addr[1:0] = 2'b00;
    endcase
  end

  always_comb begin
    be_w    = 4'b1111;
    wdata_w = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_w    = 4'b0001 << eff_addr[1:0];
        wdata_w = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_w    = eff_addr[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{wdata[15:0]}};
      end
      default: begin
        be_w    = 4'b1111;
        wdata_w = wdata;
      end
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] lane,
                                          input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (f[1:0])
      2'b00:   extract = {{24{~f[2] & b[7]}}, b};
      2'b01:   extract = {{16{~f[2] & h[15]}}, h};
      default: extract = d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_w;
  logic misaligned_q;
  always_comb begin
    mis_w = 1'b0;
    case (funct3[1:0])
      2'b00:   mis_w = 1'b0;
      2'b01:   mis_w = addr[0];
      default: mis_w = |addr[1:0];
    endcase
  end
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= 3'b000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (load_req || store_req) begin
            is_load_q   <= load_req;
            lane_q      <= eff_addr[1:0];
            size_q      <= funct3;
            mem_addr_q  <= {eff_addr[31:2], 2'b00};
            mem_we_q    <= ~load_req;
            mem_be_q    <= be_w;
            mem_wdata_q <= wdata_w;
`ifdef LSU_MISALIGN_TRAP_EN
            if (mis_w) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else begin
              state_q   <= REQ;
              mem_req_q <= 1'b1;
            end
`else
            state_q   <= REQ;
            mem_req_q <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (is_load_q) begin
              state_q <= WAIT;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= extract(mem_rdata, lane_q, size_q);
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
          misaligned_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign stall     = (state_q == IDLE && (load_req || store_req)) ||
                     state_q == REQ || state_q == WAIT;
  assign done      = done_q;
  assign rdata_out = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed vectors.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic        load_req, store_req;
  logic        stall, done, misaligned;
  logic [31:0] rdata_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .funct3(funct3),
    .load_req(load_req), .store_req(store_req), .stall(stall), .done(done),
    .rdata_out(rdata_out), .misaligned(misaligned), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } done_exp_t;

  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];
  mem_exp_t  held;
  logic      req_prev = 1'b0;
  int        total = 0;
  int        bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a memory request or a done pulse.
  always @(negedge clk) begin
    mem_exp_t  m;
    done_exp_t d;
    if (mem_req) begin
      if (!req_prev) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          m = mem_q.pop_front();
          chk("mem_addr", mem_addr, m.a);
          chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
          chk("mem_wdata", mem_wdata, m.wd);
        end
        held.a = mem_addr; held.we = mem_we; held.be = mem_be; held.wd = mem_wdata;
      end else begin
        chk("mem_addr_stable", mem_addr, held.a);
        chk("mem_be_stable", {28'd0, mem_be}, {28'd0, held.be});
        chk("mem_wdata_stable", mem_wdata, held.wd);
      end
    end
    req_prev = mem_req;
    if (done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        d = done_q.pop_front();
        chk("rdata_out", rdata_out, d.rd);
        chk("misaligned", {31'd0, misaligned}, {31'd0, d.mis});
      end
    end
  end

  task automatic access(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int gdel, input logic [31:0] rd,
                        input bit e_mem, input logic [31:0] e_a, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_rd, input bit e_mis,
                        input int e_lat);
    mem_exp_t  m;
    done_exp_t d;
    int  reqc = 0;
    bit  granted = 0;
    bit  rv = 0;
    bit  fin = 0;
    if (e_mem) begin
      m.a = e_a; m.we = !ld; m.be = e_be; m.wd = e_wd;
      mem_q.push_back(m);
    end
    d.rd = e_rd; d.mis = e_mis;
    done_q.push_back(d);
    @(negedge clk);
    load_req = ld; store_req = st; addr = a; wdata = wd; funct3 = f3;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (done) begin
        chk("latency", c + 1, e_lat);
        chk("stall_in_done", {31'd0, stall}, 32'd0);
        load_req = 1'b0; store_req = 1'b0;
        fin = 1;
      end else begin
        chk("stall_busy", {31'd0, stall}, 32'd1);
        if (mem_req && !granted) begin
          if (reqc >= gdel) begin
            mem_gnt = 1'b1; granted = 1;
          end else if (ld) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
          end
          reqc++;
        end else if (granted && ld && !rv) begin
          mem_rvalid = 1'b1; mem_rdata = rd; rv = 1;
        end
      end
    end
    if (!fin) begin
      chk("done_timeout", 32'd0, 32'd1);
      load_req = 1'b0; store_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; addr = 0; wdata = 0; funct3 = 0; load_req = 0; store_req = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);

    // SB 0x103
    access(0, 1, 32'h103, 32'h000000A5, 3'b000, 0, 32'h0,
           1, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0, 0, 2);
    // LB / LBU 0x202
    access(1, 0, 32'h202, 32'h0, 3'b000, 0, 32'h12F03456,
           1, 32'h200, 4'b0100, 32'h0, 32'hFFFFFFF0, 0, 3);
    access(1, 0, 32'h202, 32'h0, 3'b100, 0, 32'h12F03456,
           1, 32'h200, 4'b0100, 32'h0, 32'h000000F0, 0, 3);
    // SH upper half; rdata_out must keep the LBU result
    access(0, 1, 32'h2, 32'h1234ABCD, 3'b001, 0, 32'h0,
           1, 32'h0, 4'b1100, 32'hABCDABCD, 32'h000000F0, 0, 2);
    // LH with grant delayed 3 cycles and stray rvalid while waiting for grant
    access(1, 0, 32'h2, 32'h0, 3'b001, 3, 32'h80017FFF,
           1, 32'h0, 4'b1100, 32'h0, 32'hFFFF8001, 0, 6);
    // LHU lower half
    access(1, 0, 32'h0, 32'h0, 3'b101, 0, 32'h80017FFF,
           1, 32'h0, 4'b0011, 32'h0, 32'h00007FFF, 0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
    access(1, 0, 32'h6, 32'h0, 3'b010, 0, 32'hCAFEF00D,
           0, 32'h0, 4'b0000, 32'h0, 32'h00007FFF, 1, 1);
    access(0, 1, 32'h5, 32'h0000BEEF, 3'b001, 0, 32'h0,
           0, 32'h0, 4'b0000, 32'h0, 32'h00007FFF, 1, 1);
    access(1, 0, 32'h10, 32'h00000055, 3'b010, 0, 32'h11223344,
           1, 32'h10, 4'b1111, 32'h00000055, 32'h11223344, 0, 3);
`else
    access(1, 0, 32'h6, 32'h0, 3'b010, 0, 32'hCAFEF00D,
           1, 32'h4, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 3);
    access(0, 1, 32'h5, 32'h0000BEEF, 3'b001, 0, 32'h0,
           1, 32'h4, 4'b0011, 32'hBEEFBEEF, 32'hCAFEF00D, 0, 2);
    access(1, 0, 32'h10, 32'h00000055, 3'b010, 0, 32'h11223344,
           1, 32'h10, 4'b1111, 32'h00000055, 32'h11223344, 0, 3);
`endif
    // Both requests high: the load wins
    access(1, 1, 32'h10, 32'h00000077, 3'b010, 0, 32'h99887766,
           1, 32'h10, 4'b1111, 32'h00000077, 32'h99887766, 0, 3);
    // SW aligned
    access(0, 1, 32'h20, 32'hDEAD0001, 3'b010, 0, 32'h0,
           1, 32'h20, 4'b1111, 32'hDEAD0001, 32'h99887766, 0, 2);

    // Reset during WAIT, then a late rvalid for the abandoned load
    begin
      mem_exp_t m;
      m.a = 32'h30; m.we = 1'b0; m.be = 4'b1111; m.wd = 32'h0;
      mem_q.push_back(m);
    end
    @(negedge clk);
    load_req = 1; addr = 32'h30; wdata = 0; funct3 = 3'b010;
    @(negedge clk);
    chk("rw_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("rw_wait_stall", {31'd0, stall}, 32'd1);
    chk("rw_wait_req", {31'd0, mem_req}, 32'd0);
    rst = 1; load_req = 0;
    @(negedge clk);
    rst = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 0;
    repeat (4) @(negedge clk);
    chk("rw_rdata", rdata_out, 32'h0);
    chk("rw_stall", {31'd0, stall}, 32'd0);
    chk("rw_mem_req", {31'd0, mem_req}, 32'd0);

    chk("mem_q_empty", mem_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
